// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: constants and types shared by the writeback stage.
//   WIDTH       - datapath width (64)
//   load_type_e - funct3 encodings of the load instructions
//   wb_sel_e    - writeback source select encodings
//   mem_wb_t    - contents of the MEM/WB pipeline register
package wb_stage_pkg;

    localparam int WIDTH = 64;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LD  = 3'b011,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101,
        LD_LWU = 3'b110,
        LD_RSV = 3'b111
    } load_type_e;

    typedef enum logic [1:0] {
        WB_ALU     = 2'b00,
        WB_LOAD    = 2'b01,
        WB_PC4     = 2'b10,
        WB_ALU_ALT = 2'b11
    } wb_sel_e;

    typedef struct packed {
        logic             valid;
        logic [4:0]       rd;
        logic             reg_write;
        wb_sel_e          wb_select;
        load_type_e       load_type;
        logic [2:0]       addr_low;
        logic [WIDTH-1:0] data;
    } mem_wb_t;

endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: memory-stage inputs, pipeline control and register-file
// write port of the writeback stage.
//   master - driver of the memory-stage side, consumer of the write port
//   slave  - the writeback stage itself
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic             mem_valid;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic [1:0]       mem_wb_select;
    logic [2:0]       mem_load_type;
    logic [2:0]       mem_addr_low;
    logic [WIDTH-1:0] unprocess_data;
    logic             stall;
    logic             flush;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic             misaligned;

    modport master (
        output mem_valid, mem_rd, mem_reg_write, mem_wb_select, mem_load_type,
               mem_addr_low, unprocess_data, stall, flush,
        input  rf_we, rf_waddr, rf_wdata, misaligned
    );

    modport slave (
        input  mem_valid, mem_rd, mem_reg_write, mem_wb_select, mem_load_type,
               mem_addr_low, unprocess_data, stall, flush,
        output rf_we, rf_waddr, rf_wdata, misaligned
    );

endinterface

// File: rtl/wb_stage_load_ext.sv
// wb_stage_load_ext: combinational load lane selection and extension.
//   data      in  raw dword returned by memory
//   load_type in  load funct3
//   addr_low  in  byte offset of the access within the dword
//   ext_data  out extended load value (data unchanged for ld / reserved)
//   misalign  out access is not naturally aligned for its size
module wb_stage_load_ext
    import wb_stage_pkg::*;
(
    input  logic [WIDTH-1:0] data,
    input  load_type_e       load_type,
    input  logic [2:0]       addr_low,
    output logic [WIDTH-1:0] ext_data,
    output logic             misalign
);

    // Only the low word of the shifted dword is ever selected.
    logic [31:0] shifted;

    always_comb begin
        shifted  = 32'(data >> {addr_low, 3'b000});
        ext_data = data;
        misalign = 1'b0;
        case (load_type)
            LD_LB:  ext_data = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            LD_LBU: ext_data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
            LD_LH: begin
                ext_data = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
                misalign = addr_low[0];
            end
            LD_LHU: begin
                ext_data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
                misalign = addr_low[0];
            end
            LD_LW: begin
                ext_data = {{(WIDTH-32){shifted[31]}}, shifted[31:0]};
                misalign = |addr_low[1:0];
            end
            LD_LWU: begin
                ext_data = {{(WIDTH-32){1'b0}}, shifted[31:0]};
                misalign = |addr_low[1:0];
            end
            LD_LD:  misalign = |addr_low;
            default: ;  // reserved encoding: raw dword, never flagged
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the 64-bit pipeline.
// Holds the MEM/WB register (flush > stall > load), extracts load data and
// drives the register-file write port, which is also the WB forwarding source.
//   sys_clk  in  pipeline clock
//   sys_rst  in  asynchronous active-low reset
//   wb       slave modport of wb_stage_if (memory-stage inputs, stall/flush,
//            rf_we/rf_waddr/rf_wdata/misaligned outputs)
//   instret  out retired-instruction counter, present only when the macro
//            WB_INSTRET_EN is defined
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic             sys_clk,
    input  logic             sys_rst,
    wb_stage_if.slave        wb
`ifdef WB_INSTRET_EN
    ,
    output logic [WIDTH-1:0] instret
`endif
);

    mem_wb_t          entry_q, entry_d;
    logic [WIDTH-1:0] ext_data;
    logic             ext_misalign;
    logic             is_load;
    logic             misaligned_w;

    always_comb begin
        entry_d = entry_q;
        if (wb.flush) begin
            entry_d.valid = 1'b0;
        end else if (!wb.stall) begin
            entry_d.valid     = wb.mem_valid;
            entry_d.rd        = wb.mem_rd;
            entry_d.reg_write = wb.mem_reg_write;
            entry_d.wb_select = wb_sel_e'(wb.mem_wb_select);
            entry_d.load_type = load_type_e'(wb.mem_load_type);
            entry_d.addr_low  = wb.mem_addr_low;
            entry_d.data      = wb.unprocess_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) entry_q <= '0;
        else          entry_q <= entry_d;
    end

    wb_stage_load_ext u_load_ext (
        .data      (entry_q.data),
        .load_type (entry_q.load_type),
        .addr_low  (entry_q.addr_low),
        .ext_data  (ext_data),
        .misalign  (ext_misalign)
    );

    always_comb begin
        is_load      = (entry_q.wb_select == WB_LOAD);
        misaligned_w = entry_q.valid & is_load & ext_misalign;
        wb.misaligned = misaligned_w;
        wb.rf_we     = entry_q.valid & entry_q.reg_write & (entry_q.rd != 5'd0)
                       & !misaligned_w;
        wb.rf_waddr  = entry_q.rd;
        wb.rf_wdata  = is_load ? ext_data : entry_q.data;
    end

`ifdef WB_INSTRET_EN
    logic [WIDTH-1:0] instret_q, instret_d;

    // A stalled entry is counted only on the edge where it finally leaves.
    always_comb begin
        instret_d = instret_q;
        if (entry_q.valid && !wb.stall && !misaligned_w)
            instret_d = instret_q + WIDTH'(1);
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) instret_q <= '0;
        else          instret_q <= instret_d;
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: self-checking bench for wb_stage (directed vectors, stall/flush,
// asynchronous reset and randomized traffic against a behavioural model).
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    wb_stage_if wb ();
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    wb_stage dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wb      (wb)
`ifdef WB_INSTRET_EN
        ,
        .instret (instret)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit          valid;
        bit [4:0]    rd;
        bit          rw;
        bit [1:0]    sel;
        bit [2:0]    lt;
        bit [2:0]    off;
        bit [63:0]   data;
    } ref_t;

    ref_t      m;
    bit [63:0] m_instret;

    // bytes accessed by each funct3 (0 = reserved, no alignment rule)
    function automatic int ref_bytes(bit [2:0] lt);
        case (lt)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2, 3'd6: return 4;
            3'd3:       return 8;
            default:    return 0;
        endcase
    endfunction

    function automatic bit ref_mis(ref_t e);
        int n;
        n = ref_bytes(e.lt);
        if (!e.valid || e.sel != 2'b01 || n == 0) return 1'b0;
        return (int'(e.off) % n) != 0;
    endfunction

    function automatic bit [63:0] ref_wdata(ref_t e);
        int        n;
        bit [63:0] v, mask;
        n = ref_bytes(e.lt);
        if (e.sel != 2'b01 || n == 0 || n == 8) return e.data;
        v    = e.data >> (8 * int'(e.off));
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = v & mask;
        if (e.lt < 3'd4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit ref_we(ref_t e);
        return e.valid && e.rw && e.rd != 5'd0 && !ref_mis(e);
    endfunction

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic tick();
        @(posedge sys_clk);
        if (sys_rst) begin
            if (m.valid && !wb.stall && !ref_mis(m)) m_instret = m_instret + 64'd1;
            if (wb.flush) m.valid = 1'b0;
            else if (!wb.stall) begin
                m.valid = wb.mem_valid;
                m.rd    = wb.mem_rd;
                m.rw    = wb.mem_reg_write;
                m.sel   = wb.mem_wb_select;
                m.lt    = wb.mem_load_type;
                m.off   = wb.mem_addr_low;
                m.data  = wb.unprocess_data;
            end
        end
        #1;
    endtask

    task automatic set_in(bit v, bit [4:0] rd, bit rw, bit [1:0] sel, bit [2:0] lt,
                          bit [2:0] off, bit [63:0] d, bit st, bit fl);
        wb.mem_valid      = v;
        wb.mem_rd         = rd;
        wb.mem_reg_write  = rw;
        wb.mem_wb_select  = sel;
        wb.mem_load_type  = lt;
        wb.mem_addr_low   = off;
        wb.unprocess_data = d;
        wb.stall          = st;
        wb.flush          = fl;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sys_rst = 1'b0;
        set_in(1'b1, 5'd9, 1'b1, 2'b00, 3'd0, 3'd0, 64'hDEAD_BEEF_0000_1111, 1'b0, 1'b0);
        repeat (3) @(posedge sys_clk);
        #1;
        checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", wb.rf_we); end
        checks++; if (wb.rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d exp 0", wb.rf_waddr); end
        checks++; if (wb.rf_wdata !== 64'd0) begin errors++; $display("FAIL reset_wdata got %h exp 0", wb.rf_wdata); end
        checks++; if (wb.misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got %b exp 0", wb.misaligned); end
`ifdef WB_INSTRET_EN
        checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret got %0d exp 0", instret); end
`endif
        m = '{default: '0};
        m_instret = 64'd0;
        set_in(1'b0, 5'd0, 1'b0, 2'b00, 3'd0, 3'd0, 64'd0, 1'b0, 1'b0);
        sys_rst = 1'b1;
        tick();
    endtask

    typedef struct {
        bit [1:0]  sel;
        bit [2:0]  lt;
        bit [2:0]  off;
        bit [4:0]  rd;
        bit [63:0] data;
        bit        we;
        bit [63:0] wdata;
        bit        mis;
    } vec_t;

    task automatic test_directed();
        vec_t vt[7];
        bit [63:0] d;
        d = 64'h8877_6655_4433_2211;
        vt[0] = '{2'b01, 3'd0, 3'd7, 5'd5, d, 1'b1, 64'hFFFF_FFFF_FFFF_FF88, 1'b0};
        vt[1] = '{2'b01, 3'd4, 3'd7, 5'd5, d, 1'b1, 64'h0000_0000_0000_0088, 1'b0};
        vt[2] = '{2'b01, 3'd1, 3'd2, 5'd6, d, 1'b1, 64'h0000_0000_0000_4433, 1'b0};
        vt[3] = '{2'b01, 3'd6, 3'd4, 5'd7, d, 1'b1, 64'h0000_0000_8877_6655, 1'b0};
        vt[4] = '{2'b01, 3'd2, 3'd2, 5'd8, d, 1'b0, 64'h0000_0000_6655_4433, 1'b1};
        vt[5] = '{2'b01, 3'd3, 3'd0, 5'd9, d, 1'b1, d, 1'b0};
        vt[6] = '{2'b00, 3'd0, 3'd0, 5'd0, 64'h1234, 1'b0, 64'h1234, 1'b0};
        foreach (vt[i]) begin
            set_in(1'b1, vt[i].rd, 1'b1, vt[i].sel, vt[i].lt, vt[i].off, vt[i].data, 1'b0, 1'b0);
            tick();
            checks++; if (wb.rf_we !== vt[i].we) begin errors++; $display("FAIL dir%0d_we got %b exp %b", i, wb.rf_we, vt[i].we); end
            checks++; if (wb.rf_waddr !== vt[i].rd) begin errors++; $display("FAIL dir%0d_waddr got %0d exp %0d", i, wb.rf_waddr, vt[i].rd); end
            checks++; if (wb.rf_wdata !== vt[i].wdata) begin errors++; $display("FAIL dir%0d_wdata got %h exp %h", i, wb.rf_wdata, vt[i].wdata); end
            checks++; if (wb.misaligned !== vt[i].mis) begin errors++; $display("FAIL dir%0d_mis got %b exp %b", i, wb.misaligned, vt[i].mis); end
        end
    endtask

    task automatic test_stall_flush();
        set_in(1'b1, 5'd3, 1'b1, 2'b00, 3'd0, 3'd0, 64'hCAFE_F00D_1234_5678, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 3; c++) begin
            set_in(1'b1, 5'($urandom), 1'b1, 2'($urandom), 3'($urandom), 3'($urandom),
                   {$urandom, $urandom}, 1'b1, 1'b0);
            tick();
            checks++; if (wb.rf_we !== 1'b1) begin errors++; $display("FAIL stall%0d_we got %b exp 1", c, wb.rf_we); end
            checks++; if (wb.rf_waddr !== 5'd3) begin errors++; $display("FAIL stall%0d_waddr got %0d exp 3", c, wb.rf_waddr); end
            checks++; if (wb.rf_wdata !== 64'hCAFE_F00D_1234_5678) begin errors++; $display("FAIL stall%0d_wdata got %h exp cafef00d12345678", c, wb.rf_wdata); end
`ifdef WB_INSTRET_EN
            checks++; if (instret !== m_instret) begin errors++; $display("FAIL stall%0d_instret got %0d exp %0d", c, instret, m_instret); end
`endif
        end
        set_in(1'b0, 5'd0, 1'b0, 2'b00, 3'd0, 3'd0, 64'd0, 1'b0, 1'b0);
        tick();
`ifdef WB_INSTRET_EN
        checks++; if (instret !== m_instret) begin errors++; $display("FAIL stall_release_instret got %0d exp %0d", instret, m_instret); end
`endif
        // Valid entry, then stall and flush together with a valid incoming op.
        set_in(1'b1, 5'd4, 1'b1, 2'b00, 3'd0, 3'd0, 64'h55, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 5'd11, 1'b1, 2'b00, 3'd0, 3'd0, 64'h77, 1'b1, 1'b1);
        tick();
        checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("FAIL stall_flush_we got %b exp 0", wb.rf_we); end
        checks++; if (wb.misaligned !== 1'b0) begin errors++; $display("FAIL stall_flush_mis got %b exp 0", wb.misaligned); end
    endtask

    task automatic test_reset_mid();
        set_in(1'b1, 5'd12, 1'b1, 2'b01, 3'd2, 3'd1, 64'hFFFF_0000_ABCD_EF01, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 5'd13, 1'b1, 2'b00, 3'd0, 3'd0, 64'h99, 1'b0, 1'b0);
        tick();
        sys_rst = 1'b0;
        #1;
        m = '{default: '0};
        m_instret = 64'd0;
        checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("FAIL midrst_we got %b exp 0", wb.rf_we); end
        checks++; if (wb.rf_waddr !== 5'd0) begin errors++; $display("FAIL midrst_waddr got %0d exp 0", wb.rf_waddr); end
        checks++; if (wb.rf_wdata !== 64'd0) begin errors++; $display("FAIL midrst_wdata got %h exp 0", wb.rf_wdata); end
`ifdef WB_INSTRET_EN
        checks++; if (instret !== 64'd0) begin errors++; $display("FAIL midrst_instret got %0d exp 0", instret); end
`endif
        #2;
        set_in(1'b0, 5'd13, 1'b1, 2'b00, 3'd0, 3'd0, 64'h99, 1'b0, 1'b0);
        sys_rst = 1'b1;
        tick();
        checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("FAIL postrst_we got %b exp 0", wb.rf_we); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_in($urandom_range(0, 3) != 0,
                   ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                   $urandom_range(0, 4) != 0,
                   ($urandom_range(0, 1) == 0) ? 2'b01 : 2'($urandom),
                   3'($urandom), 3'($urandom), {$urandom, $urandom},
                   $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
            tick();
            checks++; if (wb.rf_we !== ref_we(m)) begin errors++; $display("FAIL rnd%0d_we got %b exp %b", c, wb.rf_we, ref_we(m)); end
            checks++; if (wb.rf_waddr !== m.rd) begin errors++; $display("FAIL rnd%0d_waddr got %0d exp %0d", c, wb.rf_waddr, m.rd); end
            checks++; if (wb.rf_wdata !== ref_wdata(m)) begin errors++; $display("FAIL rnd%0d_wdata got %h exp %h", c, wb.rf_wdata, ref_wdata(m)); end
            checks++; if (wb.misaligned !== ref_mis(m)) begin errors++; $display("FAIL rnd%0d_mis got %b exp %b", c, wb.misaligned, ref_mis(m)); end
`ifdef WB_INSTRET_EN
            checks++; if (instret !== m_instret) begin errors++; $display("FAIL rnd%0d_instret got %0d exp %0d", c, instret, m_instret); end
`endif
        end
    endtask

    initial begin
        m = '{default: '0};
        m_instret = 64'd0;
        test_reset();
        test_directed();
        test_stall_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
